// File: rtl/demux1x2_cola_pkg.sv
// Shared constants for the buffered 1-to-2 demultiplexer: default data width
// and the channel index encoding carried by sel.
package demux_pkg;

    localparam int ANCHO_POR_DEFECTO = 32;

    // sel value that steers a word to each destination channel
    localparam logic CANAL1 = 1'b0;
    localparam logic CANAL2 = 1'b1;

endpackage : demux_pkg

// File: rtl/demux1x2_cola_fifo_sinc.sv
// Single-clock FIFO with an occupancy counter; one instance per demux channel.
// The head word is always driven from storage, never bypassed from dato_in.
module fifo_sinc
    import demux_pkg::*;
#(
    parameter int ANCHO = ANCHO_POR_DEFECTO,
    parameter int PROF  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [ANCHO-1:0] dato_in,
    input  logic             pop,
    output logic [ANCHO-1:0] dato_out,
    output logic             lleno,
    output logic             vacio
);

    localparam int PUNT_W   = $clog2(PROF);
    localparam int CUENTA_W = $clog2(PROF + 1);

    logic [ANCHO-1:0]    mem [PROF];
    logic [PUNT_W-1:0]   ptr_esc;
    logic [PUNT_W-1:0]   ptr_lec;
    logic [CUENTA_W-1:0] cuenta;
    logic [CUENTA_W-1:0] cuenta_sig;
    logic                push_ok;
    logic                pop_ok;

    assign lleno    = (cuenta == CUENTA_W'(PROF));
    assign vacio    = (cuenta == '0);
    assign dato_out = mem[ptr_lec];

    // A push into a full FIFO or a pop from an empty one is dropped here as well,
    // so the counter can never over- or underflow whatever the caller does.
    assign push_ok = push && !lleno;
    assign pop_ok  = pop && !vacio;

    always_comb begin
        // NOTE: default first so every path assigns cuenta_sig and no latch is inferred.
        cuenta_sig = cuenta;
        unique case ({push_ok, pop_ok})
            2'b10:   cuenta_sig = cuenta + CUENTA_W'(1);
            2'b01:   cuenta_sig = cuenta - CUENTA_W'(1);
            default: cuenta_sig = cuenta;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            ptr_esc <= '0;
            ptr_lec <= '0;
            cuenta  <= '0;
            // NOTE: storage is cleared on reset so the heads read 0 afterwards; this
            // costs a reset on every RAM bit and rules out a plain RAM macro.
            for (int i = 0; i < PROF; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[ptr_esc] <= dato_in;
                ptr_esc      <= ptr_esc + PUNT_W'(1);
            end
            if (pop_ok) begin
                ptr_lec <= ptr_lec + PUNT_W'(1);
            end
            cuenta <= cuenta_sig;
        end
    end

endmodule : fifo_sinc

// File: rtl/demux1x2_cola.sv
// Buffered 1-to-2 demultiplexer: each accepted word goes to the FIFO picked by sel
// (0 -> channel 1, 1 -> channel 2); each channel drains independently.
module demux1x2_cola
    import demux_pkg::*;
#(
    parameter int ANCHO = ANCHO_POR_DEFECTO,
    parameter int PROF  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ANCHO-1:0] ent,
    input  logic             ent_valid,
    output logic             ent_ready,
    input  logic             sel,
    output logic [ANCHO-1:0] sal1,
    output logic             sal1_valid,
    input  logic             sal1_ready,
    output logic [ANCHO-1:0] sal2,
    output logic             sal2_valid,
    input  logic             sal2_ready
);

    logic [1:0] lleno;
    logic [1:0] vacio;
    logic       acepta;
    logic       push1;
    logic       push2;

    // Readiness looks only at the selected channel's fill state, never at the
    // consumers' ready, so there is no combinational path from sal*_ready.
    assign ent_ready = !lleno[sel];
    assign acepta    = ent_valid && ent_ready;
    assign push1     = acepta && (sel == CANAL1);
    assign push2     = acepta && (sel == CANAL2);

    assign sal1_valid = !vacio[CANAL1];
    assign sal2_valid = !vacio[CANAL2];

    fifo_sinc #(
        .ANCHO (ANCHO),
        .PROF  (PROF)
    ) u_fifo1 (
        .clk      (clk),
        .reset    (reset),
        .push     (push1),
        .dato_in  (ent),
        .pop      (sal1_valid && sal1_ready),
        .dato_out (sal1),
        .lleno    (lleno[CANAL1]),
        .vacio    (vacio[CANAL1])
    );

    fifo_sinc #(
        .ANCHO (ANCHO),
        .PROF  (PROF)
    ) u_fifo2 (
        .clk      (clk),
        .reset    (reset),
        .push     (push2),
        .dato_in  (ent),
        .pop      (sal2_valid && sal2_ready),
        .dato_out (sal2),
        .lleno    (lleno[CANAL2]),
        .vacio    (vacio[CANAL2])
    );

endmodule : demux1x2_cola

// File: tb/tb_demux1x2_cola.sv
// Self-checking bench for demux1x2_cola: a queue-based channel model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_demux1x2_cola;

    localparam int ANCHO = 32;
    localparam int PROF  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [ANCHO-1:0] ent;
    logic             ent_valid;
    logic             ent_ready;
    logic             sel;
    logic [ANCHO-1:0] sal1;
    logic             sal1_valid;
    logic             sal1_ready;
    logic [ANCHO-1:0] sal2;
    logic             sal2_valid;
    logic             sal2_ready;

    int checks   = 0;
    int failures = 0;

    demux1x2_cola #(
        .ANCHO (ANCHO),
        .PROF  (PROF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ent        (ent),
        .ent_valid  (ent_valid),
        .ent_ready  (ent_ready),
        .sel        (sel),
        .sal1       (sal1),
        .sal1_valid (sal1_valid),
        .sal1_ready (sal1_ready),
        .sal2       (sal2),
        .sal2_valid (sal2_valid),
        .sal2_ready (sal2_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [ANCHO-1:0] act, input logic [ANCHO-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: one queue of pending words per channel.
    logic [ANCHO-1:0] q1[$];
    logic [ANCHO-1:0] q2[$];
    bit               model_on = 0;
    bit               p_reset, p_push1, p_push2, p_pop1, p_pop2;
    logic [ANCHO-1:0] p_dato;

    // Compare at the falling edge, then record which transfers the model expects
    // to happen at the coming rising edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("sal1_valid", {31'd0, sal1_valid}, {31'd0, q1.size() != 0});
            check("sal2_valid", {31'd0, sal2_valid}, {31'd0, q2.size() != 0});
            if (q1.size() != 0) check("sal1_data", sal1, q1[0]);
            if (q2.size() != 0) check("sal2_data", sal2, q2[0]);
            check("ent_ready", {31'd0, ent_ready},
                  {31'd0, (sel ? q2.size() : q1.size()) < PROF});
        end
        p_reset = reset;
        p_dato  = ent;
        p_push1 = ent_valid && !sel && (q1.size() < PROF);
        p_push2 = ent_valid &&  sel && (q2.size() < PROF);
        p_pop1  = sal1_ready && (q1.size() != 0);
        p_pop2  = sal2_ready && (q2.size() != 0);
    end

    always @(posedge clk) begin
        if (p_reset) begin
            q1.delete();
            q2.delete();
            model_on = 1;
        end else if (model_on) begin
            if (p_pop1) void'(q1.pop_front());
            if (p_pop2) void'(q2.pop_front());
            if (p_push1) q1.push_back(p_dato);
            if (p_push2) q2.push_back(p_dato);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [ANCHO-1:0] d);
        ent_valid = v;
        sel       = s;
        ent       = d;
    endtask

    initial begin
        reset      = 1'b1;
        drive(1'b0, 1'b0, '0);
        sal1_ready = 1'b0;
        sal2_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state and idle readiness for both selects
        check("rst_sal1_valid", {31'd0, sal1_valid}, 32'd0);
        check("rst_sal2_valid", {31'd0, sal2_valid}, 32'd0);
        check("rst_sal1", sal1, 32'h0);
        check("rst_sal2", sal2, 32'h0);
        sel = 1'b0; #1;
        check("rst_ready_sel0", {31'd0, ent_ready}, 32'd1);
        sel = 1'b1; #1;
        check("rst_ready_sel1", {31'd0, ent_ready}, 32'd1);

        // Alternating select with both consumers ready
        sal1_ready = 1'b1;
        sal2_ready = 1'b1;
        drive(1'b1, 1'b0, 32'hA000_0001); tick();
        check("alt_w1", sal1, 32'hA000_0001);
        check("alt_w1_v", {31'd0, sal1_valid}, 32'd1);
        drive(1'b1, 1'b1, 32'hA000_0002); tick();
        check("alt_w2", sal2, 32'hA000_0002);
        check("alt_c1_empty", {31'd0, sal1_valid}, 32'd0);
        drive(1'b1, 1'b0, 32'hA000_0003); tick();
        check("alt_w3", sal1, 32'hA000_0003);
        check("alt_c2_empty", {31'd0, sal2_valid}, 32'd0);
        drive(1'b1, 1'b1, 32'hA000_0004); tick();
        check("alt_w4", sal2, 32'hA000_0004);
        drive(1'b0, 1'b0, '0); tick();

        // Full channel 1 blocks only channel 1 traffic
        sal1_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0011); tick();
        drive(1'b1, 1'b0, 32'h0000_0022); tick();
        drive(1'b1, 1'b0, 32'h0000_0033); #1;
        check("full_ready0", {31'd0, ent_ready}, 32'd0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_BEEF); #1;
        check("full_other_ready", {31'd0, ent_ready}, 32'd1);
        tick();
        check("beef_out", sal2, 32'h0000_BEEF);
        drive(1'b0, 1'b0, '0);
        sal1_ready = 1'b1; #1;
        check("drain_11", sal1, 32'h0000_0011);
        tick();
        check("drain_22", sal1, 32'h0000_0022);
        tick();
        check("drain_empty", {31'd0, sal1_valid}, 32'd0);

        // Simultaneous push and pop on channel 2; pops on empty channel 1
        sal1_ready = 1'b0;
        sal2_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_00C1); tick();
        drive(1'b1, 1'b1, 32'h0000_00C2);
        sal2_ready = 1'b1; tick();
        check("pp_head", sal2, 32'h0000_00C2);
        sal2_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_00C3); tick();
        drive(1'b0, 1'b1, 32'h0000_00C4); #1;
        check("pp_count2_full", {31'd0, ent_ready}, 32'd0);
        check("pp_head_hold", sal2, 32'h0000_00C2);
        sal1_ready = 1'b1; tick(); tick();
        check("empty_pop_v", {31'd0, sal1_valid}, 32'd0);
        sal1_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_00D1); tick();
        drive(1'b0, 1'b0, '0);
        check("after_empty_pop", sal1, 32'h0000_00D1);
        check("after_empty_pop_v", {31'd0, sal1_valid}, 32'd1);
        sal2_ready = 1'b1; tick();
        check("pp_order_c3", sal2, 32'h0000_00C3);
        tick();
        check("pp_c2_empty", {31'd0, sal2_valid}, 32'd0);
        sal1_ready = 1'b1; tick();

        // Fill both channels, then reset while offering a word
        sal1_ready = 1'b0;
        sal2_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_00E1); tick();
        drive(1'b1, 1'b0, 32'h0000_00E2); tick();
        drive(1'b1, 1'b1, 32'h0000_00E3); tick();
        drive(1'b1, 1'b1, 32'h0000_00E4); tick();
        drive(1'b1, 1'b1, 32'h0000_DEAD);
        reset = 1'b1; tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, '0);
        check("mid_rst_v1", {31'd0, sal1_valid}, 32'd0);
        check("mid_rst_v2", {31'd0, sal2_valid}, 32'd0);
        check("mid_rst_d1", sal1, 32'h0);
        check("mid_rst_d2", sal2, 32'h0);

        // Handshake presented during a reset cycle into an empty channel is dropped
        drive(1'b1, 1'b0, 32'h0000_FACE);
        reset = 1'b1; tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, '0);
        sal1_ready = 1'b1;
        sal2_ready = 1'b1;
        tick();
        check("rst_hs_v1", {31'd0, sal1_valid}, 32'd0);
        check("rst_hs_d1", sal1, 32'h0);

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            ent_valid  = ($urandom_range(0, 3) != 0);
            sel        = 1'($urandom_range(0, 1));
            ent        = $urandom;
            sal1_ready = ($urandom_range(0, 2) != 0);
            sal2_ready = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, '0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux1x2_cola
